irq_sched: RTL and testbench

- Interrupt scheduler between N interrupt sources and the core's level-sensitive interrupt port (irq / irq_id / irq_ack / ack-id).
- Latches source pulses into a pending register and applies a software-writable enable mask.
- Selects one winner and holds irq_o/irq_id_o stable until the core acknowledges that ID.
- Clears the acknowledged pending bit. Replaces the random interrupt generator in the core bench and sits in the same position in SoC builds.

---
 rtl/irq_sched_pkg.sv | 22 ++
 rtl/irq_sched_pick.sv | 47 ++++
 rtl/irq_sched.sv | 122 ++++++++++++
 tb/tb_irq_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared types, defaults and helpers for the interrupt scheduler.
package irq_sched_pkg;

   localparam int N_SRC_DEF = 32;
   localparam int ID_W_DEF  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } irq_state_e;

   // Binary index of a one-hot vector (zero when no bit is set).
   function automatic logic [31:0] onehot_to_id(input logic [31:0] oh);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         if (oh[i]) r = r | 32'(i);
      return r;
   endfunction

endpackage

// File: rtl/irq_sched_pick.sv
// irq_sched_pick: combinational winner selection among eligible sources.
// Build option IRQ_SCHED_RR_EN selects round-robin starting after ptr_i;
// otherwise the lowest eligible index wins and ptr_i is not used.
module irq_sched_pick
   import irq_sched_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic [N_SRC-1:0] elig_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic             vld_o,
   output logic [ID_W-1:0]  id_o
);

`ifdef IRQ_SCHED_RR_EN
   // Search from ptr+1 upward, wrapping modulo N_SRC; first hit wins.
   always_comb begin
      logic found;
      int   idx;
      vld_o = |elig_i;
      id_o  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = (int'(ptr_i) + k) % N_SRC;
         if (!found && elig_i[idx]) begin
            found = 1'b1;
            id_o  = ID_W'(idx);
         end
      end
   end
`else
   logic             unused_ptr;
   logic [N_SRC-1:0] lowest;

   assign unused_ptr = ^ptr_i;

   // Isolate the lowest set bit and encode it.
   always_comb begin
      vld_o  = |elig_i;
      lowest = elig_i & (~elig_i + N_SRC'(1));
      id_o   = ID_W'(onehot_to_id(32'(lowest)));
   end
`endif

endmodule

// File: rtl/irq_sched.sv
// irq_sched: latches interrupt source pulses, masks them, and presents one
// request at a time to the core, held stable until the matching ack.
// Build option IRQ_SCHED_RR_EN enables round-robin selection with a
// last-grant pointer; default is fixed lowest-index-first priority.
module irq_sched
   import irq_sched_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_SRC-1:0] src_i,
   input  logic             cfg_we_i,
   input  logic [N_SRC-1:0] cfg_mask_i,
   input  logic [N_SRC-1:0] cfg_clr_i,
   output logic             irq_o,
   output logic [ID_W-1:0]  irq_id_o,
   input  logic             irq_ack_i,
   input  logic [ID_W-1:0]  irq_ack_id_i,
   output logic [N_SRC-1:0] pending_o,
   output logic [N_SRC-1:0] mask_o,
   output logic             busy_o
);

   irq_state_e       state_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q;
   logic             irq_q;
   logic [ID_W-1:0]  id_q;
   logic [N_SRC-1:0] elig, ackclr;
   logic             ack_ok, pick_vld;
   logic [ID_W-1:0]  pick_id, ptr_w;

   // An ack is accepted only in REQ and only for the presented ID; since the
   // presented ID is always < N_SRC, out-of-range ack IDs never match.
   assign ack_ok = (state_q == REQ) && irq_ack_i && (irq_ack_id_i == id_q);
   assign elig   = pending_q & mask_q;

   // Pending next state: clears first, new source levels override them.
   always_comb begin
      ackclr    = ack_ok ? (N_SRC'(1) << irq_ack_id_i) : '0;
      pending_d = (pending_q & ~cfg_clr_i & ~ackclr) | src_i;
   end

`ifdef IRQ_SCHED_RR_EN
   logic [ID_W-1:0] ptr_q;

   // Last-grant pointer advances on every accepted ack.
   always_ff @(posedge clk_i) begin
      if (rst_i)       ptr_q <= '0;
      else if (ack_ok) ptr_q <= id_q;
   end
   assign ptr_w = ptr_q;
`else
   assign ptr_w = '0;
`endif

   irq_sched_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
      .elig_i (elig),
      .ptr_i  (ptr_w),
      .vld_o  (pick_vld),
      .id_o   (pick_id)
   );

   // Pending and mask registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (cfg_we_i) mask_q <= cfg_mask_i;
      end
   end

   // Request FSM: present a winner, hold it until ack or withdrawal, then
   // force one deasserted cycle after an ack so the core sees the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick_vld) begin
               id_q    <= pick_id;
               irq_q   <= 1'b1;
               state_q <= REQ;
            end
            REQ: if (ack_ok) begin
               irq_q   <= 1'b0;
               state_q <= GAP;
            end else if (!elig[id_q]) begin
               irq_q   <= 1'b0;
               state_q <= IDLE;
            end
            GAP: begin
               irq_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               irq_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign irq_o     = irq_q;
   assign irq_id_o  = id_q;
   assign pending_o = pending_q;
   assign mask_o    = mask_q;
   assign busy_o    = (state_q != IDLE);

   // Protocol check: the core must only acknowledge the ID it was given.
   a_ack_id: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == REQ && irq_ack_i) |-> (irq_ack_id_i == id_q))
      else $warning("irq_sched: ack id %0d differs from presented id %0d",
                    irq_ack_id_i, id_q);

endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed bench for irq_sched with an expected-ID scoreboard.
module tb_irq_sched;
   localparam int N  = 32;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  src, cfg_mask, cfg_clr, pending, mask;
   logic          cfg_we, irq, ack, busy;
   logic [IW-1:0] irq_id, ack_id;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   irq_sched #(.N_SRC(N), .ID_W(IW)) dut (
      .clk_i(clk), .rst_i(rst), .src_i(src), .cfg_we_i(cfg_we),
      .cfg_mask_i(cfg_mask), .cfg_clr_i(cfg_clr), .irq_o(irq),
      .irq_id_o(irq_id), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
      .pending_o(pending), .mask_o(mask), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pop the next expected grant and compare against the presented request.
   task automatic expect_irq(input string tag);
      int e;
      e = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_irq"}, 32'(irq), 32'd1);
      chk({tag, "_id"}, 32'(irq_id), 32'(e));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic set_mask(input logic [N-1:0] m);
      cfg_we = 1'b1; cfg_mask = m;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_src(input int i);
      src = N'(1) << i;
      step();
      src = '0;
   endtask

   task automatic do_ack(input int i);
      ack = 1'b1; ack_id = IW'(i);
      step();
      ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; src = '0; cfg_we = 1'b0; cfg_mask = '0; cfg_clr = '0;
      ack = 1'b0; ack_id = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_irq", 32'(irq), 0);
      chk("rst_id", 32'(irq_id), 0);
      chk("rst_pend", pending, 0);
      chk("rst_mask", mask, 0);
      chk("rst_busy", 32'(busy), 0);

      // Single source: 2-cycle latency, ack clears and drops irq
      set_mask('1);
      chk("mask_rb", mask, 32'hFFFF_FFFF);
      exp_q.push_back(7);
      pulse_src(7);
      chk("t1_pend", pending, 32'h80);
      chk("t1_irq_n1", 32'(irq), 0);
      step();
      expect_irq("t1");
      do_ack(7);
      chk("t1_ackirq", 32'(irq), 0);
      chk("t1_ackpend", pending, 0);
      chk("t1_gapbusy", 32'(busy), 1);
      step(); step();
      chk("t1_idle", 32'(irq), 0);

      // Two sources same cycle: lower ID first, next one at ack+3
      do_reset(); set_mask('1);
      exp_q.push_back(3); exp_q.push_back(9);
      src = (N'(1) << 3) | (N'(1) << 9);
      step(); src = '0;
      step();
      expect_irq("t2a");
      do_ack(3);
      chk("t2_m1", 32'(irq), 0);
      step();
      chk("t2_m2", 32'(irq), 0);
      step();
      expect_irq("t2b");
      do_ack(9);
      step(); step();
      chk("t2_pend", pending, 0);

      // Masking the winner withdraws; re-enabling re-presents it
      exp_q.push_back(5);
      pulse_src(5);
      step();
      expect_irq("t3a");
      set_mask(~(N'(1) << 5));
      step();
      chk("t3_wd_irq", 32'(irq), 0);
      chk("t3_wd_pend", pending, 32'h20);
      exp_q.push_back(5);
      set_mask('1);
      step();
      expect_irq("t3b");
      do_ack(5);
      step(); step();

      // Wrong-ID ack is ignored
      exp_q.push_back(4);
      pulse_src(4);
      step();
      expect_irq("t4a");
      do_ack(6);
      chk("t4_bad_irq", 32'(irq), 1);
      chk("t4_bad_id", 32'(irq_id), 4);
      chk("t4_bad_pend", pending, 32'h10);
      do_ack(4);
      chk("t4_ok_irq", 32'(irq), 0);
      chk("t4_ok_pend", pending, 0);
      step(); step();

      // Source held through its ack: stays pending and re-requests after GAP
      exp_q.push_back(2); exp_q.push_back(2);
      src = N'(1) << 2;
      step(); step();
      expect_irq("t5a");
      do_ack(2);
      chk("t5_irq", 32'(irq), 0);
      chk("t5_pend", pending, 32'h4);
      step();
      chk("t5_gap", 32'(irq), 0);
      step();
      expect_irq("t5b");
      src = '0;
      do_ack(2);
      chk("t5_clr", pending, 0);
      step(); step();

      // cfg_clr on the winner withdraws and clears it
      exp_q.push_back(8);
      pulse_src(8);
      step();
      expect_irq("t6");
      cfg_clr = N'(1) << 8;
      step();
      cfg_clr = '0;
      chk("t6_pend", pending, 0);
      step();
      chk("t6_irq", 32'(irq), 0);

      // Reset mid-request
      exp_q.push_back(1);
      pulse_src(1);
      step();
      expect_irq("t7");
      do_reset();
      chk("t7_irq", 32'(irq), 0);
      chk("t7_pend", pending, 0);
      chk("t7_mask", mask, 0);
      chk("t7_busy", 32'(busy), 0);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
